pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Control FSM that sequences program_counter and the instruction-memory fetch handshake.
- Generates every PC control input: wren, stall, branch/branch_addr, pred_branch/pred_branch_addr, halt.
- Arbitrates three redirect sources: execute-stage branch resolution, predictor, halt.
- Holds redirects that arrive mid-fetch, and keeps fetch and flush performance counters.
- Sits between the fetch stage, imem, decode hazard logic and the execute/writeback stages.

Parameters:
- word_width, 32, address/data width.
- reset_addr, 32'h00000000, value the PC is parked at during halt; reported on imem_addr in IDLE/HALTED.
- cnt_width, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; leave IDLE/HALTED and begin fetching.
- pc_q  in  word_width  current PC (program_counter inst_addr_q).
- imem_req  out  1  fetch request, level.
- imem_addr  out  word_width  fetch address.
- imem_ack  in  1  fetch data valid this cycle; only meaningful while imem_req=1.
- decode_stall  in  1  decode cannot accept an instruction.
- pred_taken  in  1  predictor says the fetched instruction is a taken branch.
- pred_addr  in  word_width  predicted target.
- ex_redirect  in  1  execute stage resolved a mispredict/taken branch.
- ex_addr  in  word_width  correct target.
- halt_req  in  1  writeback retired a halt.
- pc_wren, pc_stall, pc_branch, pc_pred_branch, pc_halt  out  1 each  program_counter controls.
- pc_branch_addr, pc_pred_addr  out  word_width  program_counter targets.
- fetch_valid  out  1  instruction on imem data is valid for decode.
- flush  out  1  kill younger in-flight instructions.
- fetch_count, flush_count  out  cnt_width  performance counters.

Behaviour:

States: IDLE, REQ, STALL, HALTED (encoding in package).

Reset: state=IDLE, pending regs cleared, counters=0. All 1-bit outputs are 0, except pc_halt=1.

Defaults: outputs 0. pc_branch_addr=ex_addr when a live ex redirect exists, else pend_addr. imem_addr=pc_q.

IDLE:
- pc_halt=1.
- start -> REQ.

REQ:
- imem_req=1.
- ex_redirect with !imem_ack: pend_valid<=1, pend_addr<=ex_addr, flush=1; stay in REQ.
- imem_ack with pend_valid or ex_redirect:
  - fetch_valid=0, flush=1, pc_wren=1, pc_branch=1.
  - Target = ex_addr if ex_redirect, else pend_addr.
  - Clear pend; stay in REQ.
- imem_ack, no redirect, !decode_stall:
  - fetch_valid=1, pc_wren=1.
  - If pred_taken: pc_pred_branch=1, pc_pred_addr=pred_addr.
  - Stay in REQ (PC+4 or target next cycle; 1 fetch per ack).
- imem_ack, no redirect, decode_stall:
  - fetch_valid=1, pc_wren=1, pc_stall=1.
  - Latch pred_taken/pred_addr into sp_valid/sp_addr; -> STALL.

STALL:
- imem_req=0, pc_wren=1.
- ex_redirect: pc_branch=1, flush=1, clear sp_valid; -> REQ (takes precedence over decode_stall).
- Else decode_stall: pc_stall=1.
- Else if sp_valid: pc_pred_branch=1, pc_pred_addr=sp_addr; -> REQ.
- Else pc_stall=0 (PC+4); -> REQ.

halt_req (any non-IDLE state, highest priority):
- pc_halt=1, flush=1, clear pend/sp; -> HALTED.
- An ack in the same cycle is dropped (fetch_valid=0).

HALTED:
- pc_halt=1 held.
- start -> REQ; start with halt_req stays HALTED.

Priority: reset > halt_req > ex_redirect > pred > sequential.

Counters:
- fetch_count +1 every cycle fetch_valid=1; flush_count +1 every cycle flush=1.
- Both wrap modulo 2^cnt_width; cleared only by reset.

Other rules:
- Reset mid-fetch: next cycle IDLE, imem_req=0; imem must tolerate a dropped request.
- A second ex_redirect while pend_valid overwrites pend_addr (youngest resolution wins).
- pc_pred_branch is never asserted together with pc_branch.

Decomposition:
- Package pc_seq_pkg: state enum type, default reset_addr, redirect-source enum (NONE, EX, PEND, PRED, SEQ) used for assertions and coverage.
- One natural sub-module: pc_seq_counters (the two saturating-free wrap counters with enable inputs).
- FSM and redirect mux stay in pc_sequencer.

Test Plan:
- Reset then start, imem_ack every cycle, no stalls -> pc_wren each cycle, fetch_valid each cycle; after 4 acks fetch_count=4 and PC 0x0→0x10.
- Ack with pred_taken=1, pred_addr=0x80 -> pc_pred_branch=1, next imem_addr=0x80, flush=0.
- ex_redirect ex_addr=0x200 two cycles before a delayed ack -> flush=1 that cycle; on ack fetch_valid=0, pc_branch=1, addr 0x200; flush_count=2.
- Ack with decode_stall for 3 cycles and pred_taken=1, pred_addr=0x40 -> pc_stall=1 for 3 cycles, PC held; then pc_pred_branch with 0x40, back in REQ.
- halt_req during STALL -> HALTED, pc_halt=1, PC=reset_addr; start -> REQ fetching reset_addr.
- reset asserted while waiting for ack with pend_valid=1 -> IDLE, imem_req=0, counters=0, no pc_branch after a following start+ack.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and defaults for the PC sequencer.
// Holds the FSM state encoding, the default parking address and the
// redirect-source classification used to steer the PC each cycle.
package pc_seq_pkg;

  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_STALL  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // Where the PC takes its next value from in a given cycle.
  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_EX   = 3'd1,
    SRC_PEND = 3'd2,
    SRC_PRED = 3'd3,
    SRC_SEQ  = 3'd4
  } redirect_src_t;

  // Execute-stage resolutions (live or held) both drive pc_branch.
  function automatic logic src_is_branch(input redirect_src_t src);
    return (src == SRC_EX) || (src == SRC_PEND);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch handshake, redirect inputs and PC control bundle.
// master = sequencer side, slave = fetch/imem/pipeline environment side.
interface pc_sequencer_if #(
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);

  logic                  start;
  logic [WORD_WIDTH-1:0] pc_q;
  logic                  imem_req;
  logic [WORD_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic                  decode_stall;
  logic                  pred_taken;
  logic [WORD_WIDTH-1:0] pred_addr;
  logic                  ex_redirect;
  logic [WORD_WIDTH-1:0] ex_addr;
  logic                  halt_req;
  logic                  pc_wren;
  logic                  pc_stall;
  logic                  pc_branch;
  logic                  pc_pred_branch;
  logic                  pc_halt;
  logic [WORD_WIDTH-1:0] pc_branch_addr;
  logic [WORD_WIDTH-1:0] pc_pred_addr;
  logic                  fetch_valid;
  logic                  flush;
  logic [CNT_WIDTH-1:0]  fetch_count;
  logic [CNT_WIDTH-1:0]  flush_count;

  modport master (
    input  start, pc_q, imem_ack, decode_stall, pred_taken, pred_addr,
           ex_redirect, ex_addr, halt_req,
    output imem_req, imem_addr, pc_wren, pc_stall, pc_branch, pc_pred_branch,
           pc_halt, pc_branch_addr, pc_pred_addr, fetch_valid, flush,
           fetch_count, flush_count
  );

  modport slave (
    output start, pc_q, imem_ack, decode_stall, pred_taken, pred_addr,
           ex_redirect, ex_addr, halt_req,
    input  imem_req, imem_addr, pc_wren, pc_stall, pc_branch, pc_pred_branch,
           pc_halt, pc_branch_addr, pc_pred_addr, fetch_valid, flush,
           fetch_count, flush_count
  );

endinterface

// File: rtl/pc_seq_counters.sv
// pc_seq_counters: fetch and flush event counters.
// Plain wrapping counters; only reset clears them.
module pc_seq_counters #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_fetch_en,
  input  logic                 i_flush_en,
  output logic [CNT_WIDTH-1:0] o_fetch_count,
  output logic [CNT_WIDTH-1:0] o_flush_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] r_fetch_count;
  logic [CNT_WIDTH-1:0] r_flush_count;

  // Count cycles with a valid fetch delivered to decode
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fetch_count <= {CNT_WIDTH{1'b0}};
    end else if (i_fetch_en) begin
      r_fetch_count <= r_fetch_count + CNT_ONE;
    end else begin
      r_fetch_count <= r_fetch_count;
    end
  end

  // Count cycles in which younger instructions are flushed
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_flush_count <= {CNT_WIDTH{1'b0}};
    end else if (i_flush_en) begin
      r_flush_count <= r_flush_count + CNT_ONE;
    end else begin
      r_flush_count <= r_flush_count;
    end
  end

  assign o_fetch_count = r_fetch_count;
  assign o_flush_count = r_flush_count;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch control FSM driving program_counter and imem.
// Arbitrates halt > execute redirect > prediction > sequential, holds
// a redirect that resolves while a fetch is outstanding, and remembers a
// prediction that arrived while decode was stalled.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                    WORD_WIDTH = 32,
  parameter int                    CNT_WIDTH  = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
  input  logic           i_clk,
  input  logic           i_reset,
  pc_sequencer_if.master io_bus
);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_pend_valid;
  logic [WORD_WIDTH-1:0] r_pend_addr;
  logic                  r_sp_valid;
  logic [WORD_WIDTH-1:0] r_sp_addr;

  logic                  w_halt_live;
  logic                  w_redirect_live;
  logic                  w_pend_set;
  logic                  w_pend_clr;
  logic                  w_sp_load;
  logic                  w_sp_clr;
  redirect_src_t         w_src;

  logic                  w_imem_req;
  logic [WORD_WIDTH-1:0] w_imem_addr;
  logic                  w_pc_wren;
  logic                  w_pc_stall;
  logic                  w_pc_halt;
  logic                  w_pc_branch;
  logic                  w_pc_pred_branch;
  logic [WORD_WIDTH-1:0] w_pc_branch_addr;
  logic [WORD_WIDTH-1:0] w_pc_pred_addr;
  logic                  w_fetch_valid;
  logic                  w_flush;
  logic [CNT_WIDTH-1:0]  w_fetch_count;
  logic [CNT_WIDTH-1:0]  w_flush_count;

  // halt_req is ignored until the sequencer has been started once
  assign w_halt_live     = io_bus.halt_req && (r_state != ST_IDLE);
  assign w_redirect_live = io_bus.ex_redirect || r_pend_valid;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state selection
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.start) begin
          w_state_next = ST_REQ;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (w_halt_live) begin
          w_state_next = ST_HALTED;
        end else if (io_bus.imem_ack && !w_redirect_live && io_bus.decode_stall) begin
          w_state_next = ST_STALL;
        end else begin
          w_state_next = ST_REQ;
        end
      end
      ST_STALL: begin
        if (w_halt_live) begin
          w_state_next = ST_HALTED;
        end else if (io_bus.ex_redirect) begin
          w_state_next = ST_REQ;
        end else if (io_bus.decode_stall) begin
          w_state_next = ST_STALL;
        end else begin
          w_state_next = ST_REQ;
        end
      end
      ST_HALTED: begin
        if (io_bus.start && !io_bus.halt_req) begin
          w_state_next = ST_REQ;
        end else begin
          w_state_next = ST_HALTED;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Per-state handshake, PC control and pending/saved-prediction strobes
  always_comb begin
    w_imem_req    = 1'b0;
    w_imem_addr   = io_bus.pc_q;
    w_pc_wren     = 1'b0;
    w_pc_stall    = 1'b0;
    w_pc_halt     = 1'b0;
    w_fetch_valid = 1'b0;
    w_flush       = 1'b0;
    w_src         = SRC_NONE;
    w_pend_set    = 1'b0;
    w_pend_clr    = 1'b0;
    w_sp_load     = 1'b0;
    w_sp_clr      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pc_halt   = 1'b1;
        w_imem_addr = RESET_ADDR;
      end
      ST_REQ: begin
        w_imem_req = 1'b1;
        if (w_halt_live) begin
          // any ack this cycle is dropped
          w_pc_halt  = 1'b1;
          w_flush    = 1'b1;
          w_pend_clr = 1'b1;
          w_sp_clr   = 1'b1;
        end else if (io_bus.ex_redirect && !io_bus.imem_ack) begin
          // hold the target until the outstanding fetch returns
          w_flush    = 1'b1;
          w_pend_set = 1'b1;
        end else if (io_bus.imem_ack && w_redirect_live) begin
          // the returning instruction is on the wrong path
          w_flush    = 1'b1;
          w_pc_wren  = 1'b1;
          w_src      = io_bus.ex_redirect ? SRC_EX : SRC_PEND;
          w_pend_clr = 1'b1;
        end else if (io_bus.imem_ack && !io_bus.decode_stall) begin
          w_fetch_valid = 1'b1;
          w_pc_wren     = 1'b1;
          w_src         = io_bus.pred_taken ? SRC_PRED : SRC_SEQ;
        end else if (io_bus.imem_ack) begin
          // decode is busy: freeze PC, remember the prediction
          w_fetch_valid = 1'b1;
          w_pc_wren     = 1'b1;
          w_pc_stall    = 1'b1;
          w_sp_load     = 1'b1;
        end else begin
          w_src = SRC_NONE;
        end
      end
      ST_STALL: begin
        if (w_halt_live) begin
          w_pc_halt  = 1'b1;
          w_flush    = 1'b1;
          w_pend_clr = 1'b1;
          w_sp_clr   = 1'b1;
        end else if (io_bus.ex_redirect) begin
          w_pc_wren = 1'b1;
          w_flush   = 1'b1;
          w_src     = SRC_EX;
          w_sp_clr  = 1'b1;
        end else if (io_bus.decode_stall) begin
          w_pc_wren  = 1'b1;
          w_pc_stall = 1'b1;
        end else if (r_sp_valid) begin
          w_pc_wren = 1'b1;
          w_src     = SRC_PRED;
          w_sp_clr  = 1'b1;
        end else begin
          w_pc_wren = 1'b1;
          w_src     = SRC_SEQ;
        end
      end
      ST_HALTED: begin
        w_pc_halt   = 1'b1;
        w_imem_addr = RESET_ADDR;
        if (io_bus.halt_req) begin
          w_flush    = 1'b1;
          w_pend_clr = 1'b1;
          w_sp_clr   = 1'b1;
        end else begin
          w_flush = 1'b0;
        end
      end
      default: begin
        w_pc_halt   = 1'b1;
        w_imem_addr = RESET_ADDR;
      end
    endcase
  end

  // Redirect mux: turn the selected source into PC branch controls
  always_comb begin
    w_pc_branch      = src_is_branch(w_src);
    w_pc_pred_branch = (w_src == SRC_PRED);
    if (w_src == SRC_PRED) begin
      w_pc_pred_addr = (r_state == ST_STALL) ? r_sp_addr : io_bus.pred_addr;
    end else begin
      w_pc_pred_addr = {WORD_WIDTH{1'b0}};
    end
    if (io_bus.ex_redirect) begin
      w_pc_branch_addr = io_bus.ex_addr;
    end else begin
      w_pc_branch_addr = r_pend_addr;
    end
  end

  // Pending execute redirect and saved prediction registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend_valid <= 1'b0;
      r_pend_addr  <= {WORD_WIDTH{1'b0}};
      r_sp_valid   <= 1'b0;
      r_sp_addr    <= {WORD_WIDTH{1'b0}};
    end else begin
      // youngest resolution overwrites an older held one
      if (w_pend_set) begin
        r_pend_valid <= 1'b1;
        r_pend_addr  <= io_bus.ex_addr;
      end else if (w_pend_clr) begin
        r_pend_valid <= 1'b0;
      end else begin
        r_pend_valid <= r_pend_valid;
      end
      if (w_sp_load) begin
        r_sp_valid <= io_bus.pred_taken;
        r_sp_addr  <= io_bus.pred_addr;
      end else if (w_sp_clr) begin
        r_sp_valid <= 1'b0;
      end else begin
        r_sp_valid <= r_sp_valid;
      end
    end
  end

  pc_seq_counters #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_counters (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_fetch_en    (w_fetch_valid),
    .i_flush_en    (w_flush),
    .o_fetch_count (w_fetch_count),
    .o_flush_count (w_flush_count)
  );

  assign io_bus.imem_req       = w_imem_req;
  assign io_bus.imem_addr      = w_imem_addr;
  assign io_bus.pc_wren        = w_pc_wren;
  assign io_bus.pc_stall       = w_pc_stall;
  assign io_bus.pc_halt        = w_pc_halt;
  assign io_bus.pc_branch      = w_pc_branch;
  assign io_bus.pc_pred_branch = w_pc_pred_branch;
  assign io_bus.pc_branch_addr = w_pc_branch_addr;
  assign io_bus.pc_pred_addr   = w_pc_pred_addr;
  assign io_bus.fetch_valid    = w_fetch_valid;
  assign io_bus.flush          = w_flush;
  assign io_bus.fetch_count    = w_fetch_count;
  assign io_bus.flush_count    = w_flush_count;

endmodule
